// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave receive front end for the PWM/clock-divider register bank.
// Synchronises sck/cs/mosi into sys_clk, shifts MSB-first frames and presents
// only frames of exactly FRAME_BITS bits. Any other length raises frame_err.
`timescale 1ns/1ps
module spi_frame_receiver #(
   parameter int unsigned FRAME_BITS  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic                  sck,
   input  logic                  cs,
   input  logic                  mosi,
   output logic [FRAME_BITS-1:0] data,
   output logic                  data_rdy,
   output logic                  frame_err
);

   localparam int unsigned   CW       = $clog2(FRAME_BITS + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
   localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME_BITS + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sck_s, cs_s, mosi_s;
   logic                   sck_d, cs_d;
   logic                   sck_rise, cs_fall, cs_rise;

   state_t                 state;
   logic [CW-1:0]          bit_cnt;
   logic [FRAME_BITS-1:0]  shift;
   logic                   commit_ok;
   logic                   commit_bad;

   // Pin synchronisers; reset to the idle bus levels (sck low, cs high, mosi low)
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync  <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      end
   end

   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // Edge-history flops on the synchronised sck and cs
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_d <= 1'b0;
         cs_d  <= 1'b1;
      end else begin
         sck_d <= sck_s;
         cs_d  <= cs_s;
      end
   end

   assign sck_rise = sck_s & ~sck_d;
   assign cs_fall  = ~cs_s & cs_d;
   assign cs_rise  = cs_s & ~cs_d;

   // Frame FSM: shift on sck_rise, judge the bit count on cs_rise.
   // The verdict is latched into commit_ok/commit_bad and applied to the
   // outputs one cycle later, so data_rdy appears SYNC_STAGES+2 edges after
   // cs rises while cs_fall still clears the flags within SYNC_STAGES+1.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift      <= '0;
         commit_ok  <= 1'b0;
         commit_bad <= 1'b0;
         data       <= '0;
         data_rdy   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         commit_ok  <= 1'b0;
         commit_bad <= 1'b0;
         if (commit_ok) begin
            data      <= shift;
            data_rdy  <= 1'b1;
            frame_err <= 1'b0;
         end
         if (commit_bad) begin
            frame_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state     <= SHIFT;
                  bit_cnt   <= '0;
                  data_rdy  <= 1'b0;
                  frame_err <= 1'b0;
               end
            end
            SHIFT: begin
               if (cs_rise) begin
                  state <= IDLE;
                  if (bit_cnt == CNT_FULL) begin
                     commit_ok <= 1'b1;
                  end else begin
                     commit_bad <= 1'b1;
                  end
               end else if (sck_rise && !cs_s) begin
                  shift <= {shift[FRAME_BITS-2:0], mosi_s};
                  if (bit_cnt != CNT_MAX) begin
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/spi_frame_receiver.md
Name: spi_frame_receiver

Overview:
- SPI slave receive front end for the PWM/clock-divider register bank. It sits directly upstream of the top-level write decoder.
- Synchronises the external sck, cs and mosi pins into sys_clk and shifts in fixed-length MSB-first frames (SPI mode 0).
- Presents a validated frame word with a level data_rdy. Malformed frames are flagged and never presented to the decoder.

Parameters:
- FRAME_BITS, 16, bits per valid frame; also the width of data.
- SYNC_STAGES, 2, flip-flop stages on each pin synchroniser (minimum 2).

Ports:
- sys_clk  input  1  system clock; all state on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sck  input  1  SPI clock pin, idle low, asynchronous to sys_clk.
- cs  input  1  SPI chip select pin, active low.
- mosi  input  1  SPI serial data in.
- data  output  FRAME_BITS  last valid frame word, MSB = first bit received.
- data_rdy  output  1  high while data holds a frame not yet superseded.
- frame_err  output  1  high when the last frame had a bit count other than FRAME_BITS.

Behaviour:
- Reset (async, rst_n low):
  - data = 0, data_rdy = 0, frame_err = 0.
  - state = IDLE, bit_cnt = 0, shift register = 0.
  - Synchroniser flops reset to sck = 0, cs = 1, mosi = 0. Edge-history flops reset to the same values.
- Synchronisers: each pin passes through SYNC_STAGES flops. Call the outputs sck_s, cs_s and mosi_s.
- Edge detect: one extra history flop each on sck_s and cs_s.
  - sck_rise = sck_s & ~sck_d.
  - cs_fall = ~cs_s & cs_d.
  - cs_rise = cs_s & ~cs_d.
- Timing constraint: sck frequency <= sys_clk/4. Mosi uses the same synchroniser depth as sck, so sampling mosi_s at sck_rise is valid for mode 0.
- IDLE state:
  - sck_rise is ignored.
  - On cs_fall: go to SHIFT, clear bit_cnt, and clear data_rdy and frame_err in that same cycle. data keeps its value.
- SHIFT state:
  - On sck_rise with cs_s low: shift = {shift[FRAME_BITS-2:0], mosi_s}.
  - bit_cnt increments, saturating at FRAME_BITS+1.
  - bit_cnt width is $clog2(FRAME_BITS+2).
- End of frame (SHIFT state, on cs_rise): return to IDLE.
  - If bit_cnt == FRAME_BITS: data <= shift, data_rdy <= 1, frame_err <= 0.
  - Otherwise (short frame, or overflow at the saturated value): frame_err <= 1. data_rdy stays 0 and data is unchanged.
- Simultaneous sck_rise and cs_rise in one cycle: cs_rise wins and the sck edge is discarded (not shifted, not counted).
- Latency: data_rdy rises on the (SYNC_STAGES+2)th sys_clk edge after the first edge that samples cs high at the pin. This is edge 4 for SYNC_STAGES = 2.
- Hold rules:
  - data_rdy and frame_err are levels. Both stay asserted until the next cs_fall.
  - data_rdy therefore always drops between consecutive frames. The downstream one-shot write logic relies on this.
  - data changes only on a valid frame end. It is never modified while data_rdy is high.
- Reset mid-frame: everything returns to reset values immediately.
  - If cs is still low at release, the synchronised cs falls from its reset value of 1 and generates cs_fall.
  - The remaining partial frame is received and ends with frame_err = 1. This is required behaviour, not a fault.
- sck or mosi activity while cs is high has no effect on any output.

Test Plan:
- Reset, then send 16 bits 0x8005 MSB-first with sck = sys_clk/8 and raise cs -> data = 0x8005, data_rdy = 1 exactly 4 sys_clk edges after cs high, frame_err = 0.
- Send 15 bits after a valid 0x1234 frame -> at cs rise frame_err = 1, data_rdy = 0, data stays 0x1234.
- Send 17 bits -> frame_err = 1, data unchanged. The next valid 16-bit frame 0x0A5A gives data = 0x0A5A and frame_err = 0.
- Back-to-back frames 0x7001 then 0x8003 -> data_rdy falls within SYNC_STAGES+1 edges of the second cs fall; it then reads 1 with data = 0x8003.
- Assert rst_n low after 8 bits of a frame, release while cs stays low, then send 8 more bits and raise cs -> outputs are 0 during reset, then frame_err = 1 and data = 0.
- Toggle sck 20 times and mosi randomly with cs held high -> data, data_rdy and frame_err stay at their prior values.
